// File: rtl/shift_register_pkg.sv
// Shared definitions for the nibble-loading shift register: shift-mode
// encodings and default widths.
package shift_register_pkg;

  // Default widths: the register holds exactly two load nibbles
  localparam int DEFAULT_IN_W   = 4;
  localparam int DEFAULT_DATA_W = 2 * DEFAULT_IN_W;

  // Shift-mode encoding as presented on the SHIFT port ({LSH,RSH})
  typedef enum logic [1:0] {
    HOLD  = 2'b00,
    RSH   = 2'b01,
    LSH   = 2'b10,
    HOLD2 = 2'b11
  } shift_mode_e;

endpackage

// File: rtl/shift_register_next.sv
// Combinational next-state logic for the shift register: computes the next
// register contents and next FLAG from the current state and the controls.
module shift_register_next
  import shift_register_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int IN_W   = DEFAULT_IN_W
) (
  input  logic [DATA_W-1:0] cur_reg,
  input  logic              cur_flag,
  input  logic [IN_W-1:0]   in1,
  input  logic              load_enable,
  input  logic [1:0]        shift,
  output logic [DATA_W-1:0] next_reg,
  output logic              next_flag
);

  shift_mode_e mode;

  assign mode = shift_mode_e'(shift);

  // Load has priority over shifting; otherwise shift by one with zero fill,
  // capturing the bit that falls off the end into FLAG, or hold.
  always_comb begin
    next_reg  = cur_reg;
    next_flag = cur_flag;
    if (load_enable) begin
      next_reg  = {cur_reg[IN_W-1:0], in1};
      next_flag = 1'b0;
    end else begin
      case (mode)
        RSH: begin
          next_reg  = {1'b0, cur_reg[DATA_W-1:1]};
          next_flag = cur_reg[0];
        end
        LSH: begin
          next_reg  = {cur_reg[DATA_W-2:0], 1'b0};
          next_flag = cur_reg[DATA_W-1];
        end
        default: begin
          next_reg  = cur_reg;
          next_flag = cur_flag;
        end
      endcase
    end
  end

endmodule

// File: rtl/shift_register.sv
// Nibble-loading shift register with logical left/right shift and a flag
// holding the most recently shifted-out bit. Output is fully registered.
module shift_register
  import shift_register_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int IN_W   = DEFAULT_IN_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [IN_W-1:0]   IN1,
  input  logic              LOAD_ENABLE,
  input  logic [1:0]        SHIFT,
  output logic [DATA_W-1:0] OUT,
  output logic              FLAG
);

  logic [DATA_W-1:0] data_reg;
  logic              flag_reg;
  logic [DATA_W-1:0] data_next;
  logic              flag_next;

  shift_register_next #(
    .DATA_W (DATA_W),
    .IN_W   (IN_W)
  ) u_next (
    .cur_reg     (data_reg),
    .cur_flag    (flag_reg),
    .in1         (IN1),
    .load_enable (LOAD_ENABLE),
    .shift       (SHIFT),
    .next_reg    (data_next),
    .next_flag   (flag_next)
  );

  // State register: DATA_W data bits plus the flag, cleared asynchronously
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      data_reg <= '0;
      flag_reg <= 1'b0;
    end else begin
      data_reg <= data_next;
      flag_reg <= flag_next;
    end
  end

  assign OUT  = data_reg;
  assign FLAG = flag_reg;

endmodule

// File: tb/tb_shift_register.sv
// Scoreboard testbench for shift_register: the driver pushes hand-computed
// expected results, a monitor pops and compares after each rising edge.
module tb_shift_register;

  localparam int DATA_W = 8;
  localparam int IN_W   = 4;

  typedef struct {
    string             name;
    logic [DATA_W-1:0] out;
    logic              flag;
  } expect_t;

  logic              CLK;
  logic              RESET;
  logic [IN_W-1:0]   IN1;
  logic              LOAD_ENABLE;
  logic [1:0]        SHIFT;
  logic [DATA_W-1:0] OUT;
  logic              FLAG;

  expect_t exp_q[$];
  int      n_checks = 0;
  int      n_fails  = 0;

  shift_register #(
    .DATA_W (DATA_W),
    .IN_W   (IN_W)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .IN1         (IN1),
    .LOAD_ENABLE (LOAD_ENABLE),
    .SHIFT       (SHIFT),
    .OUT         (OUT),
    .FLAG        (FLAG)
  );

  // Free-running clock, period 10
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Compare the DUT outputs against a required value
  task automatic checkOutput(input string name, input logic [DATA_W-1:0] exp_out,
                             input logic exp_flag);
    n_checks++;
    if (OUT !== exp_out || FLAG !== exp_flag) begin
      n_fails++;
      $display("[TB] FAIL %s: got OUT=%h FLAG=%b, required OUT=%h FLAG=%b",
               name, OUT, FLAG, exp_out, exp_flag);
    end
  endtask

  // Drive one operation between edges and queue its expected result
  task automatic applyStimulus(input string name, input logic load, input logic [1:0] shift,
                               input logic [IN_W-1:0] in1, input logic [DATA_W-1:0] exp_out,
                               input logic exp_flag);
    expect_t e;
    @(negedge CLK);
    LOAD_ENABLE = load;
    SHIFT       = shift;
    IN1         = in1;
    e.name = name;
    e.out  = exp_out;
    e.flag = exp_flag;
    exp_q.push_back(e);
  endtask

  // Monitor: each rising edge presents a result; compare the oldest pending one
  initial begin
    expect_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e.name, e.out, e.flag);
      end
    end
  end

  // Directed stimulus
  initial begin
    int budget;
    RESET       = 1'b0;
    LOAD_ENABLE = 1'b1;
    SHIFT       = 2'b01;
    IN1         = 4'hA;
    #1;
    checkOutput("reset_initial", 8'h00, 1'b0);

    @(negedge CLK);
    RESET       = 1'b1;
    LOAD_ENABLE = 1'b0;
    SHIFT       = 2'b00;

    // Load sequence from zero
    applyStimulus("load_1111", 1'b1, 2'b00, 4'hF, 8'h0F, 1'b0);
    applyStimulus("load_1101", 1'b1, 2'b00, 4'hD, 8'hFD, 1'b0);
    applyStimulus("load_1001", 1'b1, 2'b00, 4'h9, 8'hD9, 1'b0);
    applyStimulus("load_1000", 1'b1, 2'b00, 4'h8, 8'h98, 1'b0);

    // Right shifts from 0x98
    applyStimulus("rsh_1", 1'b0, 2'b01, 4'h0, 8'h4C, 1'b0);
    applyStimulus("rsh_2", 1'b0, 2'b01, 4'h0, 8'h26, 1'b0);
    applyStimulus("rsh_3", 1'b0, 2'b01, 4'h0, 8'h13, 1'b0);
    applyStimulus("rsh_4", 1'b0, 2'b01, 4'h0, 8'h09, 1'b1);
    applyStimulus("rsh_5", 1'b0, 2'b01, 4'h0, 8'h04, 1'b1);
    applyStimulus("hold00_flag1", 1'b0, 2'b00, 4'h7, 8'h04, 1'b1);

    // Back to 0x98; load also clears a set flag
    applyStimulus("reload_9", 1'b1, 2'b00, 4'h9, 8'h49, 1'b0);
    applyStimulus("reload_8", 1'b1, 2'b00, 4'h8, 8'h98, 1'b0);

    // Left shifts from 0x98
    applyStimulus("lsh_1", 1'b0, 2'b10, 4'h0, 8'h30, 1'b1);
    applyStimulus("lsh_2", 1'b0, 2'b10, 4'h0, 8'h60, 1'b0);

    // Back to 0x98, then load beats shift, then hold modes
    applyStimulus("reload2_9", 1'b1, 2'b00, 4'h9, 8'h09, 1'b0);
    applyStimulus("reload2_8", 1'b1, 2'b00, 4'h8, 8'h98, 1'b0);
    applyStimulus("load_over_rsh", 1'b1, 2'b01, 4'h3, 8'h83, 1'b0);
    applyStimulus("hold11", 1'b0, 2'b11, 4'hF, 8'h83, 1'b0);
    applyStimulus("hold00", 1'b0, 2'b00, 4'hF, 8'h83, 1'b0);

    // Continuous left shift drains to zero and stays there
    applyStimulus("drain_1", 1'b0, 2'b10, 4'h0, 8'h06, 1'b1);
    applyStimulus("drain_2", 1'b0, 2'b10, 4'h0, 8'h0C, 1'b0);
    applyStimulus("drain_3", 1'b0, 2'b10, 4'h0, 8'h18, 1'b0);
    applyStimulus("drain_4", 1'b0, 2'b10, 4'h0, 8'h30, 1'b0);
    applyStimulus("drain_5", 1'b0, 2'b10, 4'h0, 8'h60, 1'b0);
    applyStimulus("drain_6", 1'b0, 2'b10, 4'h0, 8'hC0, 1'b0);
    applyStimulus("drain_7", 1'b0, 2'b10, 4'h0, 8'h80, 1'b1);
    applyStimulus("drain_8", 1'b0, 2'b10, 4'h0, 8'h00, 1'b1);
    applyStimulus("drain_9", 1'b0, 2'b10, 4'h0, 8'h00, 1'b0);
    applyStimulus("drain_10", 1'b0, 2'b10, 4'h0, 8'h00, 1'b0);

    // Set up a right-shift sequence, then reset in the middle of it
    applyStimulus("pre_load_F", 1'b1, 2'b00, 4'hF, 8'h0F, 1'b0);
    applyStimulus("pre_load_D", 1'b1, 2'b00, 4'hD, 8'hFD, 1'b0);
    applyStimulus("pre_rsh_1", 1'b0, 2'b01, 4'h0, 8'h7E, 1'b1);
    applyStimulus("pre_rsh_2", 1'b0, 2'b01, 4'h0, 8'h3F, 1'b0);
    @(negedge CLK);
    LOAD_ENABLE = 1'b0;
    SHIFT       = 2'b01;
    #2;
    RESET = 1'b0;
    #1;
    checkOutput("reset_mid_op", 8'h00, 1'b0);
    LOAD_ENABLE = 1'b1;
    IN1         = 4'hC;
    @(negedge CLK);
    checkOutput("reset_held_1", 8'h00, 1'b0);
    @(negedge CLK);
    checkOutput("reset_held_2", 8'h00, 1'b0);
    RESET = 1'b1;

    // First edge after reset release performs the selected operation
    expect_t_push: begin
      expect_t e;
      LOAD_ENABLE = 1'b1;
      SHIFT       = 2'b10;
      IN1         = 4'h5;
      e.name = "first_after_reset";
      e.out  = 8'h05;
      e.flag = 1'b0;
      exp_q.push_back(e);
    end
    applyStimulus("post_reset_lsh", 1'b0, 2'b10, 4'h0, 8'h0A, 1'b0);

    // Wait for the scoreboard to drain, bounded
    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge CLK);
      budget--;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fails++;
      $display("[TB] FAIL scoreboard_drain: %0d results still pending, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/shift_register.md
SHIFT_REGISTER -- requirements
Module: shift_register

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning parallel output / register width.
REQ-002 SHALL have parameter IN_W, default 4, meaning load nibble width; DATA_W SHALL be 2*IN_W.
REQ-003 SHALL have port CLK  input  1  single system clock; all state updates on rising edge.
REQ-004 SHALL have port RESET  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port IN1  input  IN_W  parallel data nibble to load.
REQ-006 SHALL have port LOAD_ENABLE  input  1  load request, active-high.
REQ-007 SHALL have port SHIFT  input  2  shift mode {LSH,RSH}: 00 hold, 01 right, 10 left, 11 hold.
REQ-008 SHALL have port OUT  output  DATA_W  current register contents.
REQ-009 SHALL have port FLAG  output  1  last bit shifted out of the register.

Function
REQ-010 SHALL hold an internal DATA_W-bit register R driven directly onto OUT (registered output, no combinational path from inputs to OUT).
REQ-011 On a rising CLK with LOAD_ENABLE=1, R SHALL become {R[IN_W-1:0], IN1}; the old low nibble moves to the high nibble, the old high nibble is discarded.
REQ-012 A load SHALL clear FLAG to 0.
REQ-013 LOAD_ENABLE SHALL have priority over SHIFT; SHIFT is ignored in a load cycle.
REQ-014 With LOAD_ENABLE=0 and SHIFT=01, R SHALL become {0, R[DATA_W-1:1]} (logical right shift, zero fill) and FLAG SHALL take the old R[0].
REQ-015 With LOAD_ENABLE=0 and SHIFT=10, R SHALL become {R[DATA_W-2:0], 0} (logical left shift, zero fill) and FLAG SHALL take the old R[DATA_W-1].
REQ-016 With LOAD_ENABLE=0 and SHIFT=00 or 11, R and FLAG SHALL hold.
REQ-017 Each enabled operation SHALL take exactly one clock; the result is visible on OUT/FLAG immediately after the active edge.
REQ-018 Continuous shifting SHALL shift once per clock; after DATA_W shifts R SHALL be all zero and remain zero; FLAG then remains 0.
REQ-019 There SHALL be no rotate and no wrap-around; shifted-out bits other than the most recent are lost.

Reset
REQ-020 RESET=0 SHALL asynchronously force R (OUT) to 0 and FLAG to 0, independent of CLK.
REQ-021 RESET SHALL dominate LOAD_ENABLE and SHIFT; a reset asserted mid-sequence aborts it with no partial update.
REQ-022 After RESET deassertion, the first rising CLK SHALL perform the operation selected at that edge.

Structure
REQ-023 A shared package SHALL define the shift-mode constants (HOLD=00, RSH=01, LSH=10, HOLD2=11) and the default widths.
REQ-024 Next-state logic SHALL be one combinational function or always-block; no sub-module is required, a separate shift_next combinational sub-module is permitted.
REQ-025 The design SHALL contain exactly DATA_W+1 flip-flops.

Verification
REQ-026 Reset: RESET=0 with arbitrary inputs -> OUT=0x00, FLAG=0 without any clock edge.
REQ-027 Load sequence from 0x00: loads 1111, 1101, 1001, 1000 on successive clocks -> OUT=0x0F, 0xFD, 0xD9, 0x98; FLAG=0.
REQ-028 Right shift from 0x98 with SHIFT=01 for 5 clocks -> OUT=0x4C,0x26,0x13,0x09,0x04; FLAG=0,0,0,1,1.
REQ-029 Left shift from 0x98 with SHIFT=10 -> OUT=0x30, FLAG=1; next clock -> OUT=0x60, FLAG=0.
REQ-030 Priority/hold: LOAD_ENABLE=1 with SHIFT=01, IN1=0x3, from 0x98 -> OUT=0x83, FLAG=0; then SHIFT=11, LOAD_ENABLE=0 -> OUT stays 0x83.
REQ-031 Mid-operation reset: RESET=0 between edges during right shifting -> OUT=0x00, FLAG=0 immediately; they remain 0 while RESET=0.
